// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM states, main opcodes and the default reset vector.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select: sequential pc+4 (wrapping) or a word-aligned branch target.
module fetch_pc_next
  import mips_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_pc_next
);

  logic [31:0] w_target_aligned;

  assign o_pc_plus4       = i_pc + 32'd4;
  assign w_target_aligned = align_word(i_branch_target);
  assign o_pc_next        = i_branch_taken ? w_target_aligned : o_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: BOOT/FETCH/HOLD handshake with instruction memory and downstream consumer.
// Optional stall counter output enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        consume,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_valid;
  logic [31:0]  w_pc_next;
  logic         w_in_fetch;
  logic         w_in_hold;

  assign w_in_fetch = (r_state == FETCH);
  assign w_in_hold  = (r_state == HOLD);

  fetch_pc_next u_pc_next (
    .i_pc            (r_pc),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .o_pc_plus4      (pc_plus4),
    .o_pc_next       (w_pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      BOOT:    w_next_state = FETCH;
      FETCH:   if (imem_ack) w_next_state = HOLD;
      HOLD:    if (consume) w_next_state = FETCH;
      default: w_next_state = BOOT;
    endcase
  end

  // Acks are only honoured in FETCH, so stray or late acks never disturb the held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_VECTOR;
      r_instr <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else if (w_in_fetch && imem_ack) begin
      r_instr <= imem_rdata;
      r_valid <= 1'b1;
    end else if (w_in_hold && r_valid && consume) begin
      r_pc    <= w_pc_next;
      r_valid <= 1'b0;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'h0000_0000;
    end else if (w_in_fetch && !imem_ack) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign imem_req    = w_in_fetch;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign opcode      = r_instr[31:26];
  assign pc          = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomized memory latency, hold time and branching against a PC model.
module tb_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [5:0]  opcode;
    int unsigned stall;
  } expInstrT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        consume = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int fails = 0;

  logic [31:0] addrQ[$];
  expInstrT    instrQ[$];
  logic [31:0] modelPc;
  int unsigned modelStall;
  logic [5:0]  opTable[4];

  fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .consume       (consume),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void flagFailure(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: event did not occur as required at %0t", name, $time);
  endfunction

  // Monitor: samples on the falling edge, pops the scoreboard and checks the handshake timing rules.
  expInstrT    cur;
  logic        prevReq = 1'b0;
  logic        prevValid = 1'b0;
  logic [31:0] prevAddr = 32'h0;
  logic        ackPrev = 1'b0;
  logic        consumePrev = 1'b0;
  logic        holdPrev = 1'b0;
  int          sinceRst = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("reset_req", {31'b0, imem_req}, 32'd0);
      checkOutput("reset_valid", {31'b0, instr_valid}, 32'd0);
      checkOutput("reset_pc", pc, RV);
      checkOutput("reset_instr", instr, 32'h0);
`ifdef FETCH_STALL_CNT_EN
      checkOutput("reset_stall_cnt", stall_cnt, 32'h0);
`endif
      prevReq     = 1'b0;
      prevValid   = 1'b0;
      ackPrev     = 1'b0;
      consumePrev = 1'b0;
      holdPrev    = 1'b0;
      sinceRst    = 0;
    end else begin
      if (sinceRst < 3) sinceRst++;
      if (sinceRst == 1) checkOutput("boot_req_low", {31'b0, imem_req}, 32'd0);
      if (sinceRst == 2) checkOutput("boot_to_fetch", {31'b0, imem_req}, 32'd1);
      if (imem_req && !prevReq) begin
        if (addrQ.size() == 0) flagFailure("unexpected_req");
        else checkOutput("fetch_addr", imem_addr, addrQ.pop_front());
      end
      if (imem_req && prevReq) checkOutput("addr_stable", imem_addr, prevAddr);
      if (instr_valid && !prevValid) begin
        if (instrQ.size() == 0) flagFailure("unexpected_instr_valid");
        else begin
          cur = instrQ.pop_front();
`ifdef FETCH_STALL_CNT_EN
          checkOutput("stall_cnt", stall_cnt, cur.stall);
`endif
        end
      end
      if (instr_valid) begin
        checkOutput("instr", instr, cur.instr);
        checkOutput("pc", pc, cur.pc);
        checkOutput("pc_plus4", pc_plus4, cur.pcPlus4);
        checkOutput("opcode", {26'b0, opcode}, {26'b0, cur.opcode});
      end
      if (ackPrev) begin
        checkOutput("ack_to_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("ack_drops_req", {31'b0, imem_req}, 32'd0);
      end
      if (consumePrev) begin
        checkOutput("consume_to_req", {31'b0, imem_req}, 32'd1);
        checkOutput("consume_clears_valid", {31'b0, instr_valid}, 32'd0);
      end
      if (holdPrev) checkOutput("hold_valid", {31'b0, instr_valid}, 32'd1);
      ackPrev     = imem_req && imem_ack;
      consumePrev = instr_valid && consume;
      holdPrev    = instr_valid && !consume;
      prevReq     = imem_req;
      prevValid   = instr_valid;
      prevAddr    = imem_addr;
    end
  end

  // One full transaction: wait for the request, stall, ack, hold with noise, then consume.
  task automatic applyStimulus(input int waits, input logic [31:0] data, input int holdCycles,
                               input logic taken, input logic [31:0] target);
    int cnt = 0;
    imem_ack = 1'b0;
    while (!imem_req && cnt < 20) begin
      consume      = 1'($urandom % 2);
      branch_taken = 1'($urandom % 2);
      @(posedge clk); #1;
      cnt++;
    end
    if (!imem_req) begin
      flagFailure("req_timeout");
      return;
    end
    for (int i = 0; i < waits; i++) begin
      imem_ack      = 1'b0;
      imem_rdata    = $urandom;
      consume       = 1'($urandom % 2);
      branch_taken  = 1'($urandom % 2);
      branch_target = $urandom;
      @(posedge clk); #1;
    end
    modelStall += waits;
    instrQ.push_back('{instr: data, pc: modelPc, pcPlus4: modelPc + 32'd4,
                       opcode: data[31:26], stall: modelStall});
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(posedge clk); #1;
    consume = 1'b0;
    for (int i = 0; i < holdCycles; i++) begin
      imem_ack      = 1'($urandom % 2);
      imem_rdata    = $urandom;
      branch_taken  = 1'($urandom % 2);
      branch_target = $urandom;
      @(posedge clk); #1;
    end
    modelPc = taken ? {target[31:2], 2'b00} : modelPc + 32'd4;
    addrQ.push_back(modelPc);
    consume       = 1'b1;
    branch_taken  = taken;
    branch_target = target;
    imem_ack      = 1'($urandom % 2);
    @(posedge clk); #1;
    consume      = 1'b0;
    branch_taken = 1'b0;
    imem_ack     = 1'b0;
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    r = $urandom;
    return {opTable[$urandom % 4], r[25:0]};
  endfunction

  initial begin
    int cnt;
    opTable[0] = OP_RTYPE;
    opTable[1] = OP_LW;
    opTable[2] = OP_SW;
    opTable[3] = OP_BEQ;
    modelPc    = RV;
    modelStall = 0;
    addrQ.push_back(RV);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(0, 32'h8C22_0004, 1, 1'b1, 32'h0000_0012);
    applyStimulus(2, randInstr(), 0, 1'b0, 32'h0);
    applyStimulus(0, randInstr(), 2, 1'b1, 32'h0000_0042);
    applyStimulus(3, randInstr(), 1, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(1, randInstr(), 0, 1'b0, 32'h0);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(int'($urandom % 5), randInstr(), int'($urandom % 4),
                    1'($urandom % 2), $urandom);
    end

    cnt = 0;
    while (!imem_req && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!imem_req) flagFailure("req_timeout_before_reset");
    @(posedge clk); #1;
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    modelPc    = RV;
    modelStall = 0;
    repeat (2) @(posedge clk);
    #1;
    addrQ.push_back(RV);
    rst_n = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;

    for (int n = 0; n < 4; n++) begin
      applyStimulus(int'($urandom % 4), randInstr(), int'($urandom % 3),
                    1'($urandom % 2), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("instr_queue_drained", instrQ.size(), 32'd0);
    checkOutput("addr_queue_drained", addrQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d failures %0d", checks, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
